// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat hand dealer.
// Card ranks, deal-order states and the banker third-card table.
package baccarat_pkg;

    localparam int DEF_CARD_W   = 4;
    localparam int DEF_MAX_RANK = 13;

    typedef enum logic [3:0] {
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_EVAL1,
        S_P3,
        S_EVAL2,
        S_D3,
        S_DONE
    } state_t;

    // Ace..9 count face value; tens, faces, 0 and out-of-range ranks count 0.
    function automatic logic [3:0] card_value(
        input logic [7:0] rank,
        input int         max_rank
    );
        logic [3:0] v;
        v = 4'd0;
        if (rank >= 8'd1 && rank <= 8'd9 && int'(rank) <= max_rank) begin
            v = rank[3:0];
        end
        return v;
    endfunction

    function automatic logic banker_draws(
        input logic [3:0] dscore,
        input logic [3:0] v
    );
        logic d;
        d = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: d = 1'b1;
            4'd3:             d = (v != 4'd8);
            4'd4:             d = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             d = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             d = (v >= 4'd6) && (v <= 4'd7);
            default:          d = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hand_score.sv
// Three-card baccarat total, modulo 10.
// Purely combinational; undealt cards (rank 0) contribute nothing.
module hand_score
    import baccarat_pkg::*;
#(
    parameter int CARD_W   = DEF_CARD_W,
    parameter int MAX_RANK = DEF_MAX_RANK
) (
    input  logic [CARD_W-1:0] card1,
    input  logic [CARD_W-1:0] card2,
    input  logic [CARD_W-1:0] card3,
    output logic [3:0]        score
);

    logic [4:0] sum;

    always_comb begin
        sum = 5'(card_value(8'(card1), MAX_RANK))
            + 5'(card_value(8'(card2), MAX_RANK))
            + 5'(card_value(8'(card3), MAX_RANK));
        if (sum >= 5'd20) begin
            score = 4'(sum - 5'd20);
        end else if (sum >= 5'd10) begin
            score = 4'(sum - 5'd10);
        end else begin
            score = sum[3:0];
        end
    end

endmodule

// File: rtl/baccarat_hand.sv
// Baccarat dealer: captures cards on step, applies drawing rules, flags winner.
// Define BACCARAT_REDEAL_EN to let a step in S_DONE start a fresh hand.
module baccarat_hand
    import baccarat_pkg::*;
#(
    parameter int CARD_W   = DEF_CARD_W,
    parameter int MAX_RANK = DEF_MAX_RANK
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step,
    input  logic [CARD_W-1:0] new_card,
    output logic [CARD_W-1:0] pcard1,
    output logic [CARD_W-1:0] pcard2,
    output logic [CARD_W-1:0] pcard3,
    output logic [CARD_W-1:0] dcard1,
    output logic [CARD_W-1:0] dcard2,
    output logic [CARD_W-1:0] dcard3,
    output logic [3:0]        pscore,
    output logic [3:0]        dscore,
    output logic              done,
    output logic              player_wins,
    output logic              dealer_wins
);

    state_t            state;
    state_t            state_n;
    logic [CARD_W-1:0] p1_n;
    logic [CARD_W-1:0] p2_n;
    logic [CARD_W-1:0] p3_n;
    logic [CARD_W-1:0] d1_n;
    logic [CARD_W-1:0] d2_n;
    logic [CARD_W-1:0] d3_n;
    logic [3:0]        ps_n;
    logic [3:0]        ds_n;
    logic              fin;
    logic              clr;
    logic              done_n;
    logic              pw_n;
    logic              dw_n;

    hand_score #(.CARD_W(CARD_W), .MAX_RANK(MAX_RANK)) u_pscore (
        .card1 (pcard1),
        .card2 (pcard2),
        .card3 (pcard3),
        .score (pscore)
    );

    hand_score #(.CARD_W(CARD_W), .MAX_RANK(MAX_RANK)) u_dscore (
        .card1 (dcard1),
        .card2 (dcard2),
        .card3 (dcard3),
        .score (dscore)
    );

    // Scores of the cards as they will stand after this edge, so a D3 load
    // and the win comparison can land on the same edge.
    hand_score #(.CARD_W(CARD_W), .MAX_RANK(MAX_RANK)) u_pscore_n (
        .card1 (p1_n),
        .card2 (p2_n),
        .card3 (p3_n),
        .score (ps_n)
    );

    hand_score #(.CARD_W(CARD_W), .MAX_RANK(MAX_RANK)) u_dscore_n (
        .card1 (d1_n),
        .card2 (d2_n),
        .card3 (d3_n),
        .score (ds_n)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_P1;
            pcard1      <= '0;
            pcard2      <= '0;
            pcard3      <= '0;
            dcard1      <= '0;
            dcard2      <= '0;
            dcard3      <= '0;
            done        <= 1'b0;
            player_wins <= 1'b0;
            dealer_wins <= 1'b0;
        end else begin
            state       <= state_n;
            pcard1      <= p1_n;
            pcard2      <= p2_n;
            pcard3      <= p3_n;
            dcard1      <= d1_n;
            dcard2      <= d2_n;
            dcard3      <= d3_n;
            done        <= done_n;
            player_wins <= pw_n;
            dealer_wins <= dw_n;
        end
    end

    always_comb begin
        state_n = state;
        p1_n    = pcard1;
        p2_n    = pcard2;
        p3_n    = pcard3;
        d1_n    = dcard1;
        d2_n    = dcard2;
        d3_n    = dcard3;
        fin     = 1'b0;
        clr     = 1'b0;
        case (state)
            S_P1: if (step) begin
                p1_n    = new_card;
                state_n = S_D1;
            end
            S_D1: if (step) begin
                d1_n    = new_card;
                state_n = S_P2;
            end
            S_P2: if (step) begin
                p2_n    = new_card;
                state_n = S_D2;
            end
            S_D2: if (step) begin
                d2_n    = new_card;
                state_n = S_EVAL1;
            end
            S_EVAL1: begin
                if (pscore >= 4'd8 || dscore >= 4'd8) begin
                    fin = 1'b1;
                end else if (pscore <= 4'd5) begin
                    state_n = S_P3;
                end else if (dscore <= 4'd5) begin
                    state_n = S_D3;
                end else begin
                    fin = 1'b1;
                end
            end
            S_P3: if (step) begin
                p3_n    = new_card;
                state_n = S_EVAL2;
            end
            S_EVAL2: begin
                if (banker_draws(dscore, card_value(8'(pcard3), MAX_RANK))) begin
                    state_n = S_D3;
                end else begin
                    fin = 1'b1;
                end
            end
            S_D3: if (step) begin
                d3_n = new_card;
                fin  = 1'b1;
            end
            S_DONE: begin
`ifdef BACCARAT_REDEAL_EN
                if (step) begin
                    p1_n    = new_card;
                    p2_n    = '0;
                    p3_n    = '0;
                    d1_n    = '0;
                    d2_n    = '0;
                    d3_n    = '0;
                    clr     = 1'b1;
                    state_n = S_D1;
                end
`else
                state_n = S_DONE;
`endif
            end
            default: state_n = S_P1;
        endcase
        if (fin) begin
            state_n = S_DONE;
        end
    end

    always_comb begin
        done_n = done;
        pw_n   = player_wins;
        dw_n   = dealer_wins;
        if (fin) begin
            done_n = 1'b1;
            pw_n   = (ps_n > ds_n);
            dw_n   = (ds_n > ps_n);
        end else if (clr) begin
            done_n = 1'b0;
            pw_n   = 1'b0;
            dw_n   = 1'b0;
        end
    end

endmodule

// File: tb/tb_baccarat_hand.sv
// Directed table-driven bench for baccarat_hand.
// Each record is one hand: cards in deal order and the expected final outcome.
module tb_baccarat_hand;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       step  = 1'b0;
    logic [3:0] new_card = 4'd0;
    logic [3:0] pcard1, pcard2, pcard3;
    logic [3:0] dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;
    logic       done, player_wins, dealer_wins;

    int n_checks = 0;
    int n_fail   = 0;

    baccarat_hand dut (
        .clock       (clock),
        .reset       (reset),
        .step        (step),
        .new_card    (new_card),
        .pcard1      (pcard1),
        .pcard2      (pcard2),
        .pcard3      (pcard3),
        .dcard1      (dcard1),
        .dcard2      (dcard2),
        .dcard3      (dcard3),
        .pscore      (pscore),
        .dscore      (dscore),
        .done        (done),
        .player_wins (player_wins),
        .dealer_wins (dealer_wins)
    );

    always #5 clock = ~clock;

    typedef struct {
        int n;
        int c[6];
        int p3;
        int d3;
        int ps;
        int ds;
        int pw;
        int dw;
        int dn;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        step  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Step high for one edge, then low for one edge (lets EVAL states pass).
    task automatic deal(input int c);
        @(negedge clock);
        step     = 1'b1;
        new_card = 4'(c);
        @(negedge clock);
        step     = 1'b0;
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, " pcard1"}, int'(pcard1), 0);
        chk({tag, " dcard1"}, int'(dcard1), 0);
        chk({tag, " pcard2"}, int'(pcard2), 0);
        chk({tag, " pscore"}, int'(pscore), 0);
        chk({tag, " dscore"}, int'(dscore), 0);
        chk({tag, " done"},   int'(done),   0);
        chk({tag, " pwins"},  int'(player_wins), 0);
        chk({tag, " dwins"},  int'(dealer_wins), 0);
    endtask

    initial begin
        vt[0]  = '{4, '{4, 2, 5, 3, 0, 0},   0,  0, 9, 5, 1, 0, 0};
        vt[1]  = '{4, '{3, 7, 3, 10, 0, 0},  0,  0, 6, 7, 0, 1, 0};
        vt[2]  = '{6, '{2, 1, 1, 2, 6, 4},   6,  4, 9, 7, 1, 0, 1};
        vt[3]  = '{5, '{1, 3, 1, 3, 5, 0},   5,  0, 7, 6, 1, 0, 0};
        vt[4]  = '{4, '{12, 9, 13, 9, 0, 0}, 0,  0, 0, 8, 0, 1, 0};
        vt[5]  = '{4, '{4, 4, 4, 4, 0, 0},   0,  0, 8, 8, 0, 0, 0};
        vt[6]  = '{5, '{3, 2, 3, 3, 2, 0},   0,  2, 6, 7, 0, 1, 1};
        vt[7]  = '{4, '{15, 14, 9, 9, 0, 0}, 0,  0, 9, 9, 0, 0, 0};
        vt[8]  = '{5, '{1, 2, 1, 2, 1, 0},   1,  0, 3, 4, 0, 1, 0};
        vt[9]  = '{5, '{2, 1, 1, 2, 8, 0},   8,  0, 1, 3, 0, 1, 0};
        vt[10] = '{5, '{1, 3, 1, 4, 9, 0},   9,  0, 1, 7, 0, 1, 0};
        vt[11] = '{6, '{1, 3, 1, 3, 6, 10},  6, 10, 8, 6, 1, 0, 1};

        do_reset();
        chk_clear("reset");
        chk("reset pcard3", int'(pcard3), 0);
        chk("reset dcard3", int'(dcard3), 0);

        for (int i = 0; i < 12; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            do_reset();
            for (int k = 0; k < vt[i].n; k++) begin
                if (k > 0) chk({t, " early done"}, int'(done), 0);
                deal(vt[i].c[k]);
            end
            chk({t, " latency"}, int'(done), vt[i].dn);
            @(negedge clock);
            @(negedge clock);
            chk({t, " pcard1"}, int'(pcard1), vt[i].c[0]);
            chk({t, " dcard1"}, int'(dcard1), vt[i].c[1]);
            chk({t, " pcard2"}, int'(pcard2), vt[i].c[2]);
            chk({t, " dcard2"}, int'(dcard2), vt[i].c[3]);
            chk({t, " pcard3"}, int'(pcard3), vt[i].p3);
            chk({t, " dcard3"}, int'(dcard3), vt[i].d3);
            chk({t, " pscore"}, int'(pscore), vt[i].ps);
            chk({t, " dscore"}, int'(dscore), vt[i].ds);
            chk({t, " done"},   int'(done),   1);
            chk({t, " pwins"},  int'(player_wins), vt[i].pw);
            chk({t, " dwins"},  int'(dealer_wins), vt[i].dw);
        end

        // Step after the hand is over (hand 4 rerun).
        do_reset();
        for (int k = 0; k < 5; k++) deal(vt[3].c[k]);
        @(negedge clock);
        deal(6);
        @(negedge clock);
`ifdef BACCARAT_REDEAL_EN
        chk("redeal pcard1", int'(pcard1), 6);
        chk("redeal dcard1", int'(dcard1), 0);
        chk("redeal pcard3", int'(pcard3), 0);
        chk("redeal done",   int'(done),   0);
        chk("redeal pwins",  int'(player_wins), 0);
`else
        chk("post pcard1", int'(pcard1), 1);
        chk("post dcard3", int'(dcard3), 0);
        chk("post pcard3", int'(pcard3), 5);
        chk("post done",   int'(done),   1);
        chk("post pwins",  int'(player_wins), 1);
`endif

        // Reset mid-hand with a coincident step.
        do_reset();
        deal(4);
        deal(2);
        deal(5);
        @(negedge clock);
        reset    = 1'b1;
        step     = 1'b1;
        new_card = 4'd7;
        @(negedge clock);
        reset = 1'b0;
        step  = 1'b0;
        chk_clear("midrst");
        deal(5);
        chk("midrst pcard1", int'(pcard1), 5);
        chk("midrst dcard1", int'(dcard1), 0);
        chk("midrst pscore", int'(pscore), 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/baccarat_hand.md
Name: baccarat_hand

Overview:
- Downstream consumer of the 1..13 free-running card counter (`new_card`).
- On each `step` pulse, captures the current card into the next player/banker slot in Baccarat deal order.
- Applies the natural, player third-card and banker third-card rules, then flags the winner.
- Card registers and scores drive the display/LED stage.

Parameters:
- CARD_W, 4, width of card rank bus and card registers.
- MAX_RANK, 13, highest legal rank; ranks 10..MAX_RANK score 0.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- step  in  1  one-cycle deal pulse, already synchronised and edge-detected upstream.
- new_card  in  CARD_W  current rank from the card source (1..13).
- pcard1, pcard2, pcard3  out  CARD_W  player card registers; 0 = not dealt.
- dcard1, dcard2, dcard3  out  CARD_W  banker card registers; 0 = not dealt.
- pscore, dscore  out  4  hand totals mod 10.
- done  out  1  hand complete.
- player_wins, dealer_wins  out  1  result flags; both 0 with done=1 means tie.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: all card registers 0, scores 0, done/player_wins/dealer_wins 0, state S_P1.
- Reset overrides everything, including mid-hand and a coincident step.
- Card value: rank 1..9 gives face value; rank 0 or rank >= 10 (including illegal 14, 15) gives 0. Registers store the raw rank.
- pscore/dscore: combinational (value sum of the three cards) mod 10 from registered cards. Valid the cycle after each load.
- States: S_P1, S_D1, S_P2, S_D2, S_EVAL1, S_P3, S_EVAL2, S_D3, S_DONE.
- Deal states (S_P1, S_D1, S_P2, S_D2, S_P3, S_D3):
  - step=1 loads new_card into the matching register at that edge and advances.
  - step=0 holds.
  - A step held high for N cycles deals N cards.
- S_EVAL1: single cycle, entered after D2 loads; step ignored.
  - pscore or dscore of 8 or 9 (natural): go to S_DONE.
  - Else pscore <= 5: go to S_P3.
  - Else (player stands): dscore <= 5 goes to S_D3, otherwise S_DONE.
- S_EVAL2: single cycle after P3 loads; step ignored. Let v = value(pcard3). Banker draws (S_D3) when:
  - dscore 0..2: always.
  - 3: v != 8.
  - 4: v in 2..7.
  - 5: v in 4..7.
  - 6: v in 6..7.
  - 7: never.
  - Otherwise go to S_DONE.
- S_D3: a step loads dcard3, then go to S_DONE.
- Entry to S_DONE, all registered on the same edge:
  - done=1.
  - player_wins = pscore > dscore.
  - dealer_wins = dscore > pscore.
  - Scores are computed from the final cards, including a card loaded on that same transition. Implementation computes the next-state score for this comparison.
- Latency:
  - Last card loaded at edge k: done=1 after edge k+1 when the hand ended from S_EVAL1/S_EVAL2.
  - Hand ended by a D3 load: done=1 on the same edge as the D3 load.
- S_DONE: outputs held; step ignored (see optional feature).

Optional Feature:
- Macro BACCARAT_REDEAL_EN.
- Defined: step in S_DONE clears all cards and flags and loads new_card into pcard1 on the same edge; next state S_D1.
- Undefined: S_DONE is terminal until reset.

Decomposition:
- baccarat_pkg:
  - state enum.
  - CARD_W/MAX_RANK defaults.
  - card_value function.
  - banker_draws(dscore, v) function.
- Sub-module hand_score: combinational three-card mod-10 sum. Instantiated for the player and banker hands.

Test Plan:
1. Natural: P1=4, D1=2, P2=5, D2=3 (4 steps).
   - Expect pscore=9, dscore=5, done=1 one cycle after the 4th step.
   - player_wins=1; pcard3=dcard3=0.
2. Both stand: P1=3, D1=7, P2=3, D2=10.
   - Expect pscore=6, dscore=7, no third cards, done=1, dealer_wins=1.
3. Banker 3 draws on v=6: P1=2, D1=1, P2=1, D2=2, P3=6, D3=4.
   - Expect pscore=9, dscore=7, player_wins=1.
4. Banker 6 stands on v=5: P1=1, D1=3, P2=1, D2=3, P3=5.
   - Expect dcard3=0, pscore=7, dscore=6, player_wins=1; a 6th step changes nothing (feature off).
5. Face/mod: P1=12, D1=9, P2=13, D2=9.
   - Expect pscore=0, dscore=8 (natural), dealer_wins=1.
6. Reset mid-hand after 3 steps:
   - Next edge: all cards 0, scores 0, done=0.
   - Following step with new_card=5 gives pcard1=5.
   - With BACCARAT_REDEAL_EN: step in S_DONE gives pcard1=new_card and all other cards 0.
